seq_det_ctrl: RTL and testbench

Programmable serial-pattern detection controller.
- Accepts a pattern, length, overlap mode and match limit over a valid/ready config port.
- Runs the detection session when armed and started, and counts matches.
- Raises done when the limit is reached.
- Sits between the bit-serial input stream and the control/status logic. Replaces fixed-pattern detector FSMs with one reusable, configurable engine.

---
 rtl/seq_det_ctrl.sv | 158 +++++++++++++++
 tb/tb_seq_det_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Configurable serial-pattern detector: latches pattern/length/overlap/limit over a
// valid/ready port, then scans a qualified bit stream and counts matches.
module seq_det_ctrl #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_limit,
   input  logic             start,
   input  logic             abort,
   input  logic             x_valid,
   input  logic             x,
   output logic             y,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy,
   output logic             done,
   output logic [1:0]       dbg_state
);

   // Config handshake: a transfer happens on a rising edge where cfg_valid and
   // cfg_ready are both high; cfg_ready is low only while a session is scanning.
   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SCAN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [PAT_W-1:0] r_pattern;
   logic [LEN_W-1:0] r_len;
   logic             r_overlap;
   logic [CNT_W-1:0] r_limit;
   logic [PAT_W-1:0] r_hist;
   logic [LEN_W-1:0] r_fill;
   logic [CNT_W-1:0] r_cnt;
   logic             r_y;

   logic             w_cfg_hs;
   logic             w_start_scan;
   logic             w_sample;
   logic             w_full;
   logic             w_match;
   logic             w_limit_hit;
   logic [PAT_W-1:0] w_hist_next;
   logic [PAT_W-1:0] w_mask;
   logic [LEN_W:0]   w_fill_inc;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [LEN_W-1:0] w_len_clamped;

   assign cfg_ready   = (r_state != S_SCAN);
   assign w_cfg_hs    = cfg_valid & cfg_ready;
   assign w_start_scan = start & ~abort & ((r_state == S_ARMED) | (r_state == S_DONE));
   assign w_sample    = (r_state == S_SCAN) & x_valid & ~abort;
   assign w_hist_next = (r_hist << 1) | PAT_W'(x);
   assign w_fill_inc  = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
   assign w_full      = (w_fill_inc >= {1'b0, r_len});
   assign w_match     = w_sample & w_full & (((w_hist_next ^ r_pattern) & w_mask) == '0);
   assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_limit_hit = w_match & (r_limit != '0) & (w_cnt_inc == r_limit);

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         w_mask[i] = (i < int'(r_len));
      end
   end

   // Zero-length patterns behave as single-bit ones; overlong lengths saturate.
   always_comb begin
      w_len_clamped = cfg_len;
      if (cfg_len == '0) begin
         w_len_clamped = LEN_W'(1);
      end else if (cfg_len > LEN_W'(PAT_W)) begin
         w_len_clamped = LEN_W'(PAT_W);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_cfg_hs) w_state_next = S_ARMED;
         end
         S_ARMED: begin
            if (abort)      w_state_next = S_IDLE;
            else if (start) w_state_next = S_SCAN;
         end
         S_SCAN: begin
            if (abort)            w_state_next = S_IDLE;
            else if (w_limit_hit) w_state_next = S_DONE;
         end
         S_DONE: begin
            if (abort)         w_state_next = S_IDLE;
            else if (start)    w_state_next = S_SCAN;
            else if (w_cfg_hs) w_state_next = S_ARMED;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pattern <= '0;
         r_len     <= '0;
         r_overlap <= 1'b0;
         r_limit   <= '0;
         r_hist    <= '0;
         r_fill    <= '0;
         r_cnt     <= '0;
         r_y       <= 1'b0;
      end else begin
         r_y <= w_match;
         if (w_cfg_hs) begin
            r_pattern <= cfg_pattern;
            r_len     <= w_len_clamped;
            r_overlap <= cfg_overlap;
            r_limit   <= cfg_limit;
         end
         if (w_start_scan) begin
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
         end else if (w_sample) begin
            r_hist <= w_hist_next;
            // Without overlap a match consumes its bits, so the window refills from empty.
            if (w_match && !r_overlap) begin
               r_fill <= '0;
            end else if (w_full) begin
               r_fill <= r_len;
            end else begin
               r_fill <= w_fill_inc[LEN_W-1:0];
            end
            if (w_match) begin
               r_cnt <= w_cnt_inc;
            end
         end
      end
   end

   assign y         = r_y;
   assign match_cnt = r_cnt;
   assign busy      = (r_state == S_SCAN);
   assign done      = (r_state == S_DONE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus random sessions checked against a
// bit-queue reference model; match pulses are scoreboarded through an expected queue.
module tb_seq_det_ctrl;
   localparam int PAT_W = 8;
   localparam int LEN_W = 4;
   localparam int CNT_W = 8;
   localparam int M_IDLE = 0, M_ARMED = 1, M_SCAN = 2, M_DONE = 3;

   logic             clk, rst;
   logic             cfg_valid, cfg_ready, cfg_overlap;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic [CNT_W-1:0] cfg_limit, match_cnt;
   logic             start, abort, x_valid, x, y, busy, done;
   logic [1:0]       dbg_state;

   int n_cmp = 0;
   int n_fail = 0;
   logic [CNT_W-1:0] exp_q[$];

   // reference model: the valid bits seen in the current window, newest at the back
   logic [PAT_W-1:0] m_pat;
   int               m_len, m_lim, m_cnt, m_mode;
   bit               m_ovl;
   bit               m_bits[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   seq_det_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cfg_limit(cfg_limit), .start(start), .abort(abort), .x_valid(x_valid), .x(x),
      .y(y), .match_cnt(match_cnt), .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // monitor: every y pulse must correspond to a predicted match carrying its count
   always @(negedge clk) begin
      if (rst && y) begin
         if (exp_q.size() == 0) check("y_unexpected", 32'(y), 32'd0);
         else check("y_match_cnt", 32'(match_cnt), 32'(exp_q.pop_front()));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_pat = '0; m_len = 1; m_lim = 0; m_cnt = 0; m_ovl = 1'b0;
      m_bits.delete();
   endtask

   task automatic check_status(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'(m_mode == M_SCAN));
      check({tag, "_done"}, 32'(done), 32'(m_mode == M_DONE));
      check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'(m_mode != M_SCAN));
      check({tag, "_match_cnt"}, 32'(match_cnt), 32'(m_cnt));
   endtask

   task automatic configure(input logic [PAT_W-1:0] pat, input int len, input bit ovl, input int lim);
      cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = LEN_W'(len);
      cfg_overlap = ovl; cfg_limit = CNT_W'(lim);
      if (m_mode != M_SCAN) begin
         m_pat = pat; m_ovl = ovl; m_lim = lim;
         m_len = (len == 0) ? 1 : (len > PAT_W) ? PAT_W : len;
         m_mode = M_ARMED;
      end
      cyc();
      cfg_valid = 1'b0; cfg_pattern = PAT_W'($urandom);
   endtask

   task automatic do_start();
      start = 1'b1;
      if (m_mode == M_ARMED || m_mode == M_DONE) begin
         m_mode = M_SCAN; m_cnt = 0; m_bits.delete();
      end
      cyc();
      start = 1'b0;
   endtask

   task automatic model_step(input bit v, input bit b, input bit ab);
      bit hit;
      if (ab) begin
         m_mode = M_IDLE;
      end else if (m_mode == M_SCAN && v) begin
         m_bits.push_back(b);
         if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
         hit = (m_bits.size() >= m_len);
         for (int k = 0; k < m_len && hit; k++)
            if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
         if (hit) begin
            m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
            exp_q.push_back(CNT_W'(m_cnt));
            if (!m_ovl) m_bits.delete();
            if (m_lim != 0 && m_cnt == m_lim) m_mode = M_DONE;
         end
      end
   endtask

   task automatic send(input bit v, input bit b, input bit ab);
      x_valid = v; x = b; abort = ab;
      model_step(v, b, ab);
      cyc();
      x_valid = 1'b0; abort = 1'b0; x = 1'($urandom_range(0, 1));
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) send(1'b1, bits[i], 1'b0);
   endtask

   task automatic drain(input string tag);
      cyc();
      check({tag, "_pending_y"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b0; cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
      cfg_limit = '0; start = 0; abort = 0; x_valid = 0; x = 0;
      model_reset();
      #12;
      check("rst_y", 32'(y), 32'd0);
      check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      check("rst_dbg_known", 32'($isunknown(dbg_state)), 32'd0);
      check_status("rst");
      rst = 1'b1;
      cyc();

      // overlapping 1001
      configure(8'h09, 4, 1'b1, 0);
      do_start();
      send_bits(16'b1001001, 7);
      check("t1_cnt", 32'(match_cnt), 32'd2);
      check("t1_busy", 32'(busy), 32'd1);
      drain("t1");
      send(1'b0, 1'b0, 1'b1);

      // non-overlapping 1001
      configure(8'h09, 4, 1'b0, 0);
      do_start();
      send_bits(16'b1001001, 7);
      check("t2_cnt", 32'(match_cnt), 32'd1);
      drain("t2");
      send(1'b0, 1'b0, 1'b1);

      // 11 with limit 2, then restart from DONE
      configure(8'h03, 2, 1'b1, 2);
      do_start();
      send_bits(16'b111, 3);
      check("t3_done", 32'(done), 32'd1);
      check("t3_busy", 32'(busy), 32'd0);
      check("t3_cnt", 32'(match_cnt), 32'd2);
      check_status("t3");
      drain("t3");
      do_start();
      check("t3_restart_cnt", 32'(match_cnt), 32'd0);
      check("t3_restart_busy", 32'(busy), 32'd1);
      send(1'b0, 1'b0, 1'b1);

      // 1001 with invalid gap cycles carrying garbage
      configure(8'h09, 4, 1'b1, 0);
      do_start();
      send(1, 1, 0); send(0, 1, 0); send(0, 0, 0); send(1, 0, 0); send(0, 1, 0);
      send(1, 0, 0); send(0, 1, 0); send(0, 0, 0); send(0, 1, 0); send(1, 1, 0);
      check("t4_cnt", 32'(match_cnt), 32'd1);
      drain("t4");
      send(1'b0, 1'b0, 1'b1);

      // abort on the completing bit
      configure(8'h09, 4, 1'b1, 0);
      do_start();
      send_bits(16'b100100, 6);
      send(1'b1, 1'b1, 1'b1);
      check("t5_y", 32'(y), 32'd0);
      check("t5_cnt", 32'(match_cnt), 32'd1);
      check("t5_cfg_ready", 32'(cfg_ready), 32'd1);
      do_start();
      check("t5_start_ignored", 32'(busy), 32'd0);
      check_status("t5");
      drain("t5");

      // zero length behaves as single bit
      configure(8'h01, 0, 1'b0, 0);
      do_start();
      send_bits(16'b10110, 5);
      check("t7_cnt", 32'(match_cnt), 32'd3);
      drain("t7");

      // asynchronous reset right after a match edge
      send(1'b0, 1'b0, 1'b1);
      configure(8'h09, 4, 1'b1, 0);
      do_start();
      send_bits(16'b1001, 4);
      check("t6_y_before", 32'(y), 32'd1);
      #1 rst = 1'b0;
      #1;
      check("t6_y", 32'(y), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_done", 32'(done), 32'd0);
      check("t6_cnt", 32'(match_cnt), 32'd0);
      check("t6_cfg_ready", 32'(cfg_ready), 32'd1);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      cyc();

      // random sessions
      for (int r = 0; r < 25; r++) begin
         if (m_mode == M_SCAN) send(1'b0, 1'b0, 1'b1);
         configure(PAT_W'($urandom),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
         do_start();
         for (int i = 0; i < 40; i++) begin
            int c;
            c = int'($urandom_range(0, 39));
            if (c == 0) do_start();
            else if (c == 1) configure(PAT_W'($urandom), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            else if (m_mode == M_DONE && c < 12) do_start();
            else send($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 79) == 0);
            check_status("rnd");
         end
         drain("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
